// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter.
//   state_t          : measurement FSM states (S_CLEAR, S_GATE, S_LATCH)
//   BCD_ADD3_THRESH  : double-dabble digit threshold; digits at or above it get +3
//   gate_cnt_w()     : width of the gate counter for a given gate length
//   bcd_digits()     : decimal digits needed for a CNT_W-bit count, ceil(CNT_W*log10 2)
//   dd_adjust()      : one double-dabble digit correction
package freq_meter_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam int BCD_ADD3_THRESH = 5;

  function automatic int gate_cnt_w(input int gate_cycles);
    return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
  endfunction

  // 30103/100000 approximates log10(2); rounding up gives the digit count.
  function automatic int bcd_digits(input int cnt_w);
    return (cnt_w * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'(BCD_ADD3_THRESH)) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus rising-edge detector for an asynchronous input.
// The input passes through SYNC_STAGES flops; O_EDGE is a registered
// one-cycle pulse, SYNC_STAGES+1 cycles after the input rises.
// Ports:
//   I_CLK  : clock, rising edge
//   rst    : synchronous active-high reset (clears every flop)
//   I_SIG  : asynchronous input
//   O_EDGE : one-cycle rising-edge pulse
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic I_CLK,
  input  logic rst,
  input  logic I_SIG,
  output logic O_EDGE
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
      O_EDGE  <= 1'b0;
    end else begin
      // p0: synchronizer chain
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], I_SIG};
      // p1: previous synchronized level and edge pulse
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      O_EDGE  <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of I_SIG over a gate of GATE_CYCLES
// I_CLK cycles. One measurement takes GATE_CYCLES+2 cycles (clear, gate,
// latch); edges in the clear/latch cycles are not counted.
// Ports:
//   I_CLK       : system clock, rising edge
//   rst         : synchronous active-high reset; aborts a gate in progress
//   I_SIG       : measured signal, asynchronous
//   O_FREQ      : edge count of the last completed gate (saturating)
//   O_VALID     : one-cycle strobe when O_FREQ/O_OVF update
//   O_OVF       : last gate's count saturated
//   O_BCD       : decimal form of O_FREQ (all 9s on overflow)   [FREQ_METER_BCD_EN]
//   O_BCD_VALID : one-cycle strobe, CNT_W+1 cycles after O_VALID [FREQ_METER_BCD_EN]
// Build option: define FREQ_METER_BCD_EN to add the sequential BCD converter.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_FREQ,
  output logic             O_VALID,
  output logic             O_OVF
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [4*bcd_digits(CNT_W)-1:0] O_BCD,
  output logic                           O_BCD_VALID
`endif
);

  localparam int            GW        = gate_cnt_w(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             edge_p0;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .I_CLK (I_CLK),
    .rst   (rst),
    .I_SIG (I_SIG),
    .O_EDGE(edge_p0)
  );

  always_ff @(posedge I_CLK) begin
    if (rst) state <= S_CLEAR;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR: next_state = S_GATE;
      S_GATE:  if (gate_cnt == GATE_LAST) next_state = S_LATCH;
      S_LATCH: next_state = S_CLEAR;
      default: next_state = S_CLEAR;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      O_FREQ   <= '0;
      O_OVF    <= 1'b0;
      O_VALID  <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      case (state)
        S_CLEAR: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
        end
        S_GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          // Counter holds at all-ones; any further edge marks the gate saturated.
          if (edge_p0) begin
            if (&edge_cnt) sat      <= 1'b1;
            else           edge_cnt <= edge_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          O_FREQ  <= edge_cnt;
          O_OVF   <= sat;
          O_VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FREQ_METER_BCD_EN
  localparam int DIGITS = bcd_digits(CNT_W);
  localparam int BW     = 4 * DIGITS;
  localparam int LW     = $clog2(CNT_W + 1);

  logic [BW+CNT_W-1:0] dd_p0;
  logic [BW+CNT_W-1:0] dd_next;
  logic [LW-1:0]       dd_left;
  logic                dd_busy;

  // One double-dabble iteration: correct every BCD digit, then shift left.
  function automatic logic [BW+CNT_W-1:0] dd_step(input logic [BW+CNT_W-1:0] v);
    logic [BW+CNT_W-1:0] t;
    t = v;
    for (int d = 0; d < DIGITS; d++)
      t[CNT_W+4*d +: 4] = dd_adjust(t[CNT_W+4*d +: 4]);
    return {t[BW+CNT_W-2:0], 1'b0};
  endfunction

  assign dd_next = dd_step(dd_p0);

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      dd_left     <= '0;
      dd_busy     <= 1'b0;
      O_BCD       <= '0;
      O_BCD_VALID <= 1'b0;
    end else begin
      O_BCD_VALID <= 1'b0;
      // A fresh strobe always reloads, restarting any conversion in flight.
      if (O_VALID) begin
        dd_left <= LW'(CNT_W);
        dd_busy <= 1'b1;
      end else if (dd_busy) begin
        dd_left <= dd_left - 1'b1;
        if (dd_left == LW'(1)) begin
          dd_busy     <= 1'b0;
          O_BCD       <= O_OVF ? {DIGITS{4'd9}} : dd_next[BW+CNT_W-1 -: BW];
          O_BCD_VALID <= 1'b1;
        end
      end
    end
  end

  // p0: conversion shift register (data path, no reset needed)
  always_ff @(posedge I_CLK) begin
    if (O_VALID)      dd_p0 <= {{BW{1'b0}}, O_FREQ};
    else if (dd_busy) dd_p0 <= dd_next;
  end
`endif

endmodule
